// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 16 x 16 register file: two valid/ready writeback requesters
// share one registered write port; also keeps the pending-write scoreboard for hazard checks.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic                         clock,
  input  logic                         reset_n,

  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [ADDR_WIDTH-1:0]        a_reg,
  input  logic [DATA_WIDTH-1:0]        a_data,

  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [ADDR_WIDTH-1:0]        b_reg,
  input  logic [DATA_WIDTH-1:0]        b_data,

  input  logic                         hold,

  input  logic                         issue_valid,
  input  logic [ADDR_WIDTH-1:0]        issue_reg,
  input  logic [ADDR_WIDTH-1:0]        rs1,
  input  logic [ADDR_WIDTH-1:0]        rs2,
  output logic                         rs1_busy,
  output logic                         rs2_busy,
  output logic [(2**ADDR_WIDTH)-1:0]   busy_mask,

  output logic [ADDR_WIDTH-1:0]        rf_write_register,
  output logic [DATA_WIDTH-1:0]        rf_write_value,
  output logic                         rf_regWrite_signal,
  output logic                         last_grant
);

  localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;

  logic                  grant_a;
  logic                  grant_b;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] win_reg;
  logic [DATA_WIDTH-1:0] win_data;

  logic [ADDR_WIDTH-1:0] wr_reg_q,     wr_reg_d;
  logic [DATA_WIDTH-1:0] wr_data_q,    wr_data_d;
  logic                  wr_en_q,      wr_en_d;
  logic                  last_grant_q, last_grant_d;
  logic [NUM_REGS-1:0]   busy_q,       busy_d;
  logic [NUM_REGS-1:0]   set_vec;
  logic [NUM_REGS-1:0]   clr_vec;

  // Grant: on contention the side that did not win last time goes first (last_grant_q=1 means B won).
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset_n && !hold) begin
      if (a_valid && b_valid) begin
        if (FIXED_PRIORITY || last_grant_q) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign accept   = grant_a | grant_b;
  assign win_reg  = grant_a ? a_reg  : b_reg;
  assign win_data = grant_a ? a_data : b_data;

  // Output write-port register; address and value hold when nothing is accepted.
  always_comb begin
    wr_reg_d     = wr_reg_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    last_grant_d = last_grant_q;
    if (accept) begin
      wr_reg_d     = win_reg;
      wr_data_d    = win_data;
      wr_en_d      = 1'b1;
      last_grant_d = grant_b;
    end
  end

  // Scoreboard: a new issue to a register wins over a writeback retiring the same register.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid) begin
      set_vec[issue_reg] = 1'b1;
    end
    if (accept) begin
      clr_vec[win_reg] = 1'b1;
    end
    busy_d = set_vec | (busy_q & ~clr_vec);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_reg_q     <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= '0;
    end else begin
      wr_reg_q     <= wr_reg_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign rf_write_register  = wr_reg_q;
  assign rf_write_value     = wr_data_q;
  assign rf_regWrite_signal = wr_en_q;
  assign last_grant         = last_grant_q;
  assign busy_mask          = busy_q;
  assign rs1_busy           = busy_q[rs1];
  assign rs2_busy           = busy_q[rs2];

endmodule
